// File: rtl/e203_ifu_bhtbpu.sv
// IFU branch predictor: PC-indexed 2-bit BHT for conditional branches plus a
// circular return-address stack for JALR returns; next-PC operands are combinational.
module e203_ifu_bhtbpu #(
    parameter int PC_SIZE     = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int RAS_DEPTH   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PC_SIZE-1:0] pc,
    input  logic               dec_i_valid,
    input  logic               dec_fire,
    input  logic               dec_rv32,
    input  logic               dec_jal,
    input  logic               dec_jalr,
    input  logic               dec_bxx,
    input  logic [PC_SIZE-1:0] dec_bjp_imm,
    input  logic [4:0]         dec_jalr_rs1idx,
    input  logic [4:0]         dec_rdidx,
    input  logic               oitf_empty,
    input  logic               jalr_rs1idx_cam_irrdidx,
    input  logic [PC_SIZE-1:0] rf2bpu_x1,
    input  logic               ras_flush,
    input  logic               upd_valid,
    input  logic [PC_SIZE-1:0] upd_pc,
    input  logic               upd_taken,
    output logic               prdt_taken,
    output logic [PC_SIZE-1:0] prdt_pc_add_op1,
    output logic [PC_SIZE-1:0] prdt_pc_add_op2,
    output logic               bpu_wait,
    output logic               prdt_ras_hit
);

    localparam int IW = $clog2(BHT_ENTRIES);
    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CW = $clog2(RAS_DEPTH + 1);
    localparam logic [PW-1:0] TOP_MAX = PW'(RAS_DEPTH - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(RAS_DEPTH);

    logic [1:0]         bht [BHT_ENTRIES];
    logic [PC_SIZE-1:0] ras [RAS_DEPTH];
    logic [PW-1:0]      top;
    logic [CW-1:0]      cnt;

    logic [IW-1:0] rd_idx, up_idx;
    logic          unused_upd_pc;
    assign rd_idx        = pc[IW:1];
    assign up_idx        = upd_pc[IW:1];
    assign unused_upd_pc = ^upd_pc;

    // JAL wins if the decoder ever flags more than one class.
    logic jalr_eff, lrs1, lrd, rs1_ne_rd, rs1_x0, rs1_x1, ras_empty;
    assign jalr_eff  = dec_jalr & ~dec_jal;
    assign lrs1      = (dec_jalr_rs1idx == 5'd1) | (dec_jalr_rs1idx == 5'd5);
    assign lrd       = (dec_rdidx == 5'd1) | (dec_rdidx == 5'd5);
    assign rs1_ne_rd = dec_jalr_rs1idx != dec_rdidx;
    assign rs1_x0    = dec_jalr_rs1idx == 5'd0;
    assign rs1_x1    = dec_jalr_rs1idx == 5'd1;
    assign ras_empty = cnt == '0;

    logic ras_hit, x1_path;
    assign ras_hit = jalr_eff & ~rs1_x0 & lrs1 & rs1_ne_rd & ~ras_empty;
    assign x1_path = jalr_eff & rs1_x1 & ras_empty;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        prdt_taken      = 1'b0;
        prdt_pc_add_op1 = pc;
        if (dec_jal) begin
            prdt_taken = 1'b1;
        end else if (jalr_eff) begin
            if (rs1_x0) begin
                prdt_taken      = 1'b1;
                prdt_pc_add_op1 = '0;
            end else if (ras_hit) begin
                prdt_taken      = 1'b1;
                prdt_pc_add_op1 = ras[top];
            end else if (x1_path) begin
                prdt_taken      = 1'b1;
                prdt_pc_add_op1 = rf2bpu_x1;
            end
        end else if (dec_bxx) begin
            prdt_taken = bht[rd_idx][1];
        end
    end

    assign prdt_pc_add_op2 = dec_bjp_imm;
    assign bpu_wait        = dec_i_valid & x1_path & (~oitf_empty | jalr_rs1idx_cam_irrdidx);
    assign prdt_ras_hit    = dec_i_valid & ras_hit;

    // NOTE: the BHT must come out of reset weakly not-taken, so this array is reset;
    // RAS data is never read while count is 0 and is left without reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
        end else if (upd_valid) begin
            if (upd_taken && bht[up_idx] != 2'b11)
                bht[up_idx] <= bht[up_idx] + 2'b01;
            else if (!upd_taken && bht[up_idx] != 2'b00)
                bht[up_idx] <= bht[up_idx] - 2'b01;
        end
    end

    logic [PC_SIZE-1:0] la;
    logic               ras_upd, do_push, do_pop, do_replace;
    logic [PW-1:0]      top_inc, top_dec;

    assign la      = pc + (dec_rv32 ? PC_SIZE'(4) : PC_SIZE'(2));
    assign ras_upd = dec_fire & dec_i_valid & ~ras_flush;
    // A pop-then-push on an empty stack degenerates to a plain push.
    assign do_push = (dec_jal & lrd)
                   | (jalr_eff & lrd & ~(lrs1 & rs1_ne_rd))
                   | (jalr_eff & lrs1 & lrd & rs1_ne_rd & ras_empty);
    assign do_pop     = jalr_eff & lrs1 & ~lrd & ~ras_empty;
    assign do_replace = jalr_eff & lrs1 & lrd & rs1_ne_rd & ~ras_empty;
    assign top_inc    = (top == TOP_MAX) ? '0 : top + PW'(1);
    assign top_dec    = (top == '0) ? TOP_MAX : top - PW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            top <= '0;
            cnt <= '0;
        end else if (ras_flush) begin
            top <= '0;
            cnt <= '0;
        end else if (ras_upd) begin
            if (do_push) begin
                top <= top_inc;
                if (cnt != CNT_MAX) cnt <= cnt + CW'(1);
            end else if (do_pop) begin
                top <= top_dec;
                cnt <= cnt - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ras_upd) begin
            if (do_push)         ras[top_inc] <= la;
            else if (do_replace) ras[top]     <= la;
        end
    end

endmodule

// File: tb/tb_e203_ifu_bhtbpu.sv
// Self-checking bench for e203_ifu_bhtbpu: directed scenarios followed by random
// traffic, compared against a queue/array reference model of the predictor.
module tb_e203_ifu_bhtbpu;

    localparam int PC_SIZE     = 32;
    localparam int BHT_ENTRIES = 64;
    localparam int RAS_DEPTH   = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc, dec_bjp_imm, rf2bpu_x1, upd_pc;
    logic        dec_i_valid, dec_fire, dec_rv32, dec_jal, dec_jalr, dec_bxx;
    logic [4:0]  dec_jalr_rs1idx, dec_rdidx;
    logic        oitf_empty, jalr_rs1idx_cam_irrdidx, ras_flush, upd_valid, upd_taken;
    logic        prdt_taken, bpu_wait, prdt_ras_hit;
    logic [31:0] prdt_pc_add_op1, prdt_pc_add_op2;

    int checks   = 0;
    int failures = 0;

    logic [1:0]  bht_m [BHT_ENTRIES];
    logic [31:0] ras_q [$];

    always #5 clk = ~clk;

    e203_ifu_bhtbpu #(.PC_SIZE(PC_SIZE), .BHT_ENTRIES(BHT_ENTRIES), .RAS_DEPTH(RAS_DEPTH)) dut (
        .clk(clk), .rst(rst), .pc(pc), .dec_i_valid(dec_i_valid), .dec_fire(dec_fire),
        .dec_rv32(dec_rv32), .dec_jal(dec_jal), .dec_jalr(dec_jalr), .dec_bxx(dec_bxx),
        .dec_bjp_imm(dec_bjp_imm), .dec_jalr_rs1idx(dec_jalr_rs1idx), .dec_rdidx(dec_rdidx),
        .oitf_empty(oitf_empty), .jalr_rs1idx_cam_irrdidx(jalr_rs1idx_cam_irrdidx),
        .rf2bpu_x1(rf2bpu_x1), .ras_flush(ras_flush), .upd_valid(upd_valid), .upd_pc(upd_pc),
        .upd_taken(upd_taken), .prdt_taken(prdt_taken), .prdt_pc_add_op1(prdt_pc_add_op1),
        .prdt_pc_add_op2(prdt_pc_add_op2), .bpu_wait(bpu_wait), .prdt_ras_hit(prdt_ras_hit)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int bidx(input logic [31:0] a);
        return int'((a >> 1) % BHT_ENTRIES);
    endfunction

    function automatic bit is_link(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd5);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < BHT_ENTRIES; i++) bht_m[i] = 2'b01;
        ras_q.delete();
    endtask

    task automatic ras_push(input logic [31:0] a);
        ras_q.push_back(a);
        if (ras_q.size() > RAS_DEPTH) void'(ras_q.pop_front());
    endtask

    task automatic predict(output logic taken, output logic [31:0] op1,
                           output logic w, output logic hit);
        taken = 1'b0; op1 = pc; w = 1'b0; hit = 1'b0;
        if (dec_jal) begin
            taken = 1'b1;
        end else if (dec_jalr) begin
            if (dec_jalr_rs1idx == 0) begin
                taken = 1'b1; op1 = 32'h0;
            end else if (is_link(dec_jalr_rs1idx) && dec_jalr_rs1idx != dec_rdidx && ras_q.size() > 0) begin
                taken = 1'b1; op1 = ras_q[ras_q.size()-1]; hit = dec_i_valid;
            end else if (dec_jalr_rs1idx == 1 && ras_q.size() == 0) begin
                taken = 1'b1; op1 = rf2bpu_x1;
                w = dec_i_valid & (~oitf_empty | jalr_rs1idx_cam_irrdidx);
            end
        end else if (dec_bxx) begin
            taken = bht_m[bidx(pc)] >= 2'd2;
        end
    endtask

    task automatic model_update();
        logic [31:0] la;
        int i;
        if (upd_valid) begin
            i = bidx(upd_pc);
            if (upd_taken && bht_m[i] != 2'd3) bht_m[i] = bht_m[i] + 2'd1;
            else if (!upd_taken && bht_m[i] != 2'd0) bht_m[i] = bht_m[i] - 2'd1;
        end
        if (ras_flush) begin
            ras_q.delete();
        end else if (dec_i_valid && dec_fire) begin
            la = pc + (dec_rv32 ? 32'd4 : 32'd2);
            if (dec_jal) begin
                if (is_link(dec_rdidx)) ras_push(la);
            end else if (dec_jalr) begin
                if (is_link(dec_jalr_rs1idx) && is_link(dec_rdidx) && dec_jalr_rs1idx != dec_rdidx) begin
                    if (ras_q.size() > 0) ras_q[ras_q.size()-1] = la;
                    else ras_push(la);
                end else if (is_link(dec_rdidx)) begin
                    ras_push(la);
                end else if (is_link(dec_jalr_rs1idx) && ras_q.size() > 0) begin
                    void'(ras_q.pop_back());
                end
            end
        end
    endtask

    task automatic settle(input string tag);
        logic et, ew, eh;
        logic [31:0] eo;
        #1;
        predict(et, eo, ew, eh);
        check({tag, "/taken"}, 32'(prdt_taken), 32'(et));
        check({tag, "/op1"}, prdt_pc_add_op1, eo);
        check({tag, "/op2"}, prdt_pc_add_op2, dec_bjp_imm);
        check({tag, "/wait"}, 32'(bpu_wait), 32'(ew));
        check({tag, "/hit"}, 32'(prdt_ras_hit), 32'(eh));
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle();
        pc = 32'h0; dec_bjp_imm = 32'h0; rf2bpu_x1 = 32'hdead_beef; upd_pc = 32'h0;
        dec_i_valid = 0; dec_fire = 0; dec_rv32 = 1; dec_jal = 0; dec_jalr = 0; dec_bxx = 0;
        dec_jalr_rs1idx = 0; dec_rdidx = 0; oitf_empty = 1; jalr_rs1idx_cam_irrdidx = 0;
        ras_flush = 0; upd_valid = 0; upd_taken = 0;
    endtask

    task automatic set_bxx(input logic [31:0] a, input logic [31:0] imm);
        idle(); pc = a; dec_bjp_imm = imm; dec_bxx = 1; dec_i_valid = 1; dec_fire = 1;
    endtask

    task automatic set_jal(input logic [31:0] a, input logic [4:0] rd, input logic rv32, input logic fire);
        idle(); pc = a; dec_jal = 1; dec_rdidx = rd; dec_rv32 = rv32; dec_i_valid = 1; dec_fire = fire;
    endtask

    task automatic set_jalr(input logic [31:0] a, input logic [4:0] rs1, input logic [4:0] rd, input logic fire);
        idle(); pc = a; dec_jalr = 1; dec_jalr_rs1idx = rs1; dec_rdidx = rd; dec_i_valid = 1; dec_fire = fire;
    endtask

    task automatic bht_upd(input logic [31:0] a, input logic t);
        idle(); upd_valid = 1; upd_pc = a; upd_taken = t;
        tick();
    endtask

    initial begin
        logic [31:0] exp_pop [4];
        idle();
        model_reset();
        repeat (2) @(negedge clk);
        settle("in_reset");
        rst = 0;
        @(negedge clk);
        settle("idle");

        set_bxx(32'h8000_0010, 32'h20);
        settle("bxx_cold");
        check("bxx_cold_taken_lit", 32'(prdt_taken), 32'h0);
        check("bxx_cold_op1_lit", prdt_pc_add_op1, 32'h8000_0010);
        check("bxx_cold_op2_lit", prdt_pc_add_op2, 32'h20);
        tick();

        repeat (2) bht_upd(32'h8000_0010, 1);
        set_bxx(32'h8000_0010, 32'h20);
        settle("bxx_trained");
        check("bxx_trained_lit", 32'(prdt_taken), 32'h1);
        tick();
        repeat (3) bht_upd(32'h8000_0010, 1);
        bht_upd(32'h8000_0010, 0);
        set_bxx(32'h8000_0010, 32'h40);
        settle("bxx_weak_taken");
        check("bxx_weak_taken_lit", 32'(prdt_taken), 32'h1);

        upd_valid = 1; upd_pc = 32'h8000_0010; upd_taken = 0;
        settle("collide");
        check("collide_old_lit", 32'(prdt_taken), 32'h1);
        tick();
        set_bxx(32'h8000_0010, 32'h40);
        settle("after_collide");
        check("after_collide_lit", 32'(prdt_taken), 32'h0);
        tick();

        set_jal(32'h100, 5'd1, 1, 1);
        settle("call");
        tick();
        set_jalr(32'h200, 5'd1, 5'd0, 1);
        oitf_empty = 0;
        settle("ret");
        check("ret_hit_lit", 32'(prdt_ras_hit), 32'h1);
        check("ret_op1_lit", prdt_pc_add_op1, 32'h104);
        check("ret_wait_lit", 32'(bpu_wait), 32'h0);
        tick();
        set_jalr(32'h204, 5'd1, 5'd0, 1);
        settle("ret_empty");
        check("ret_empty_op1_lit", prdt_pc_add_op1, 32'hdead_beef);
        tick();

        for (int i = 1; i <= 5; i++) begin
            set_jal(32'(i * 16), 5'd1, 0, 1);
            settle("push");
            tick();
        end
        exp_pop = '{32'h52, 32'h42, 32'h32, 32'h22};
        for (int i = 0; i < 4; i++) begin
            set_jalr(32'h300, 5'd1, 5'd0, 1);
            settle("pop");
            check("pop_lit", prdt_pc_add_op1, exp_pop[i]);
            tick();
        end
        set_jalr(32'h300, 5'd1, 5'd0, 0);
        jalr_rs1idx_cam_irrdidx = 1; rf2bpu_x1 = 32'h1234_5678;
        settle("pop_miss");
        check("pop_miss_wait_lit", 32'(bpu_wait), 32'h1);
        check("pop_miss_op1_lit", prdt_pc_add_op1, 32'h1234_5678);
        tick();

        set_jal(32'h400, 5'd1, 1, 1);
        ras_flush = 1;
        settle("flush_jal");
        tick();
        set_jalr(32'h500, 5'd5, 5'd0, 1);
        settle("after_flush");
        check("after_flush_taken_lit", 32'(prdt_taken), 32'h0);
        check("after_flush_op1_lit", prdt_pc_add_op1, 32'h500);
        tick();

        set_jal(32'h600, 5'd1, 1, 0);
        settle("unfired_jal");
        tick();
        set_jal(32'h700, 5'd1, 1, 1);
        settle("call2");
        tick();
        set_jalr(32'h800, 5'd5, 5'd1, 1);
        settle("poppush");
        check("poppush_op1_lit", prdt_pc_add_op1, 32'h704);
        tick();
        set_jalr(32'h900, 5'd1, 5'd0, 1);
        settle("after_poppush");
        check("after_poppush_lit", prdt_pc_add_op1, 32'h804);
        tick();

        repeat (3) bht_upd(32'h8000_0010, 1);
        set_jal(32'hA00, 5'd1, 1, 1);
        tick();
        idle();
        #2 rst = 1;
        #1 rst = 0;
        model_reset();
        set_bxx(32'h8000_0010, 32'h8);
        settle("async_rst_bht");
        check("async_rst_bht_lit", 32'(prdt_taken), 32'h0);
        tick();
        set_jalr(32'hB00, 5'd1, 5'd0, 1);
        settle("async_rst_ras");
        check("async_rst_ras_lit", 32'(prdt_ras_hit), 32'h0);
        tick();

        for (int n = 0; n < 1500; n++) begin
            int cls;
            logic [4:0] regs [4];
            idle();
            case ($urandom_range(0, 3))
                0: pc = $urandom();
                1: pc = 32'hFFFF_FFFE;
                default: pc = 32'h8000_0000 | (32'($urandom_range(0, 255)) << 1);
            endcase
            regs = '{5'd0, 5'd1, 5'd5, 5'($urandom_range(0, 31))};
            cls = $urandom_range(0, 3);
            dec_jal  = (cls == 1);
            dec_jalr = (cls == 2);
            dec_bxx  = (cls == 3);
            dec_jalr_rs1idx = regs[$urandom_range(0, 3)];
            dec_rdidx       = regs[$urandom_range(0, 3)];
            dec_rv32    = 1'($urandom());
            dec_i_valid = $urandom_range(0, 7) != 0;
            dec_fire    = $urandom_range(0, 3) != 0;
            dec_bjp_imm = $urandom();
            rf2bpu_x1   = $urandom();
            oitf_empty  = 1'($urandom());
            jalr_rs1idx_cam_irrdidx = 1'($urandom());
            ras_flush   = $urandom_range(0, 15) == 0;
            upd_valid   = 1'($urandom());
            upd_taken   = 1'($urandom());
            upd_pc      = $urandom_range(0, 1) ? pc : 32'h8000_0000 | (32'($urandom_range(0, 255)) << 1);
            settle("rnd");
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
